morph3x3_filter: RTL and testbench
==================================

Name: morph3x3_filter

Overview:
- Parametrised 3x3 greyscale morphology stage: erosion (min) or dilation (max) over a cross (5-point) or square (9-point) structuring element.
- Consumes three vertically aligned row streams from an upstream line buffer.
- Produces one filtered pixel per accepted input beat, with a fixed pipeline latency.
- Used as the building block for opening and closing chains, where erode and dilate instances are cascaded.

Parameters:
- DATA_W, 24: pixel width in bits, applied to all data ports.
- PIC_WIDTH, 250: pixels per line; sizes the column counter.
- COL_W, 11: column counter width; must satisfy 2^COL_W >= PIC_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  input beat qualifier
- sol  in  1  start of line; qualified by valid_in
- mode  in  1  0 = erode (min), 1 = dilate (max); sampled per beat
- shape  in  1  0 = cross, 1 = square; sampled per beat
- din_top  in  DATA_W  row y-1 pixel
- din_mid  in  DATA_W  row y pixel
- din_bot  in  DATA_W  row y+1 pixel
- valid_out  out  1  output beat qualifier
- dout  out  DATA_W  filtered pixel
- col_out  out  COL_W  centre column of dout

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: all window registers, pipeline registers, dout, col_out and the column counter go to 0; valid_out goes to 0.
- Window:
  - On each valid_in beat, each row shifts into a 3-deep register chain: newest (c+1), centre (c), oldest (c-1).
  - With valid_in low, the window holds. No stall input; bubbles propagate.
- Column counter col:
  - Counts valid_in beats 0..PIC_WIDTH-1, then wraps to 0.
  - Holds while valid_in is low.
  - valid_in && sol forces the beat's column to 0, so the counter reads 1 next.
- Centre column: the beat carrying column k produces the result for centre k-1. The beat carrying column 0 produces the result for centre PIC_WIDTH-1 of the previous line.
- Pipeline:
  - S0 = window shift. S1 = per-row partial min/max plus column tag. S2 = final combine, registered into dout, col_out and valid_out.
  - valid_out rises exactly 2 clk edges after the edge that samples valid_in.
  - While valid_out is low, dout and col_out hold their last values.
- Operand selection:
  - Cross: centre, up, down, left, right.
  - Square: all 9 window positions.
  - Compare is unsigned, full DATA_W. Ties are irrelevant because the value is unique.
- mode and shape travel with their beat through the pipeline. Changing either between beats is legal and takes effect from that beat's result.
- The first beat after reset or sol uses the reset-zero or stale window. Its output is still emitted, and is garbage unless masked (see Optional Feature).
- Reset asserted mid-line: everything clears immediately. The next line must start with sol.

Optional Feature:
- Macro: MORPH_BORDER_MASK_EN.
- Defined:
  - At centre column 0, the left column operands are replaced by the neutral value.
  - At centre column PIC_WIDTH-1, the right column operands are replaced by the neutral value.
  - Neutral value is all-ones for erode and 0 for dilate.
  - The mask decision uses the beat's col tag, computed in S0.
- Undefined: raw window; pixels wrap across line boundaries, with no mask logic.

Decomposition:
- Package morph_pkg holds:
  - constants MODE_ERODE = 1'b0, MODE_DILATE = 1'b1, SHAPE_CROSS = 1'b0, SHAPE_SQUARE = 1'b1;
  - a function for the neutral value given mode and width.
- Sub-module morph_sel2: combinational 2-input min/max selected by mode, parametrised by DATA_W. It is instantiated for the S1 and S2 compare trees.
- Column counter and masking stay in the top level.

Test Plan (DATA_W=8, PIC_WIDTH=8, continuous valid, sol on each col 0):
- Erode, cross, all rows 100 except din_mid col 3 = 20:
  - centres 2, 3, 4 -> dout 20; other centres -> 100;
  - valid_out exactly 2 edges after each valid_in beat.
- Dilate, square, all rows 10 except din_top col 5 = 200:
  - centres 4, 5, 6 -> 200; others -> 10;
  - col_out tracks the centre column.
- Border, erode, din_mid col 0 = 5, others 50:
  - with MORPH_BORDER_MASK_EN, centre 7 of the preceding line -> 50 and centre 0 -> 5;
  - without the macro, centre 7 -> 5.
- Gapped input, valid_in every other cycle, same data as scenario 1:
  - identical dout sequence;
  - number of valid_out pulses equals number of valid_in pulses.
- Per-beat mode switch, alternating mode each beat on scenario 1 data:
  - results alternate between min and max of the same windows (e.g. centre 3: erode 20, dilate 100).
- Reset low at col 4 mid-line:
  - dout = 0, valid_out = 0, col = 0 immediately;
  - after release, sol at the next beat gives col_out sequence 7, 0, 1...

Source files
------------

// File: rtl/morph_pkg.sv
// Shared constants and helpers for the 3x3 morphology datapath.
// Optional build macro: MORPH_BORDER_MASK_EN (neutral-value masking of the
// left/right window columns at line edges).
package morph_pkg;

   localparam logic MODE_ERODE   = 1'b0;
   localparam logic MODE_DILATE  = 1'b1;
   localparam logic SHAPE_CROSS  = 1'b0;
   localparam logic SHAPE_SQUARE = 1'b1;

   // Value that never wins the compare: all-ones for min, zero for max.
   // Returned 64 bits wide; callers truncate to their pixel width.
   function automatic logic [63:0] neutral_val(input logic mode, input int unsigned width);
      logic [63:0] ones;
      ones = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (mode == MODE_ERODE) ? ones : 64'd0;
   endfunction

endpackage

// File: rtl/morph_sel2.sv
// Two-input unsigned min/max element used to build the compare trees.
module morph_sel2
   import morph_pkg::*;
#(
   parameter int DATA_W = 24
) (
   input  logic              mode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   // Dilate keeps the larger operand, erode the smaller one.
   always_comb begin
      if (mode == MODE_DILATE) y = (a > b) ? a : b;
      else                     y = (a < b) ? a : b;
   end

endmodule

// File: rtl/morph3x3_filter.sv
// 3x3 greyscale erode/dilate over a cross or square structuring element.
// Three-stage pipeline: S0 window shift + column tag, S1 per-row partials,
// S2 final combine into dout/col_out/valid_out.
// Optional build macro: MORPH_BORDER_MASK_EN replaces the out-of-line window
// column with the neutral value at centre columns 0 and PIC_WIDTH-1.
module morph3x3_filter
   import morph_pkg::*;
#(
   parameter int DATA_W    = 24,
   parameter int PIC_WIDTH = 250,
   parameter int COL_W     = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic              sol,
   input  logic              mode,
   input  logic              shape,
   input  logic [DATA_W-1:0] din_top,
   input  logic [DATA_W-1:0] din_mid,
   input  logic [DATA_W-1:0] din_bot,
   output logic              valid_out,
   output logic [DATA_W-1:0] dout,
   output logic [COL_W-1:0]  col_out
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIC_WIDTH - 1);

   // Column counter and per-beat column bookkeeping
   logic [COL_W-1:0]  col_cnt;
   logic [COL_W-1:0]  beat_col;
   logic [COL_W-1:0]  ctr_col;

   // S0 window: index 0 = oldest (c-1), 1 = centre (c), 2 = newest (c+1)
   logic [DATA_W-1:0] top_p0 [3];
   logic [DATA_W-1:0] mid_p0 [3];
   logic [DATA_W-1:0] bot_p0 [3];
   logic [COL_W-1:0]  col_p0;
   logic              mode_p0;
   logic              shape_p0;
   logic              vld_p0;

   // S1 operands after optional border masking
   logic [DATA_W-1:0] lt, lm, lb, rt, rm, rb;
   logic [DATA_W-1:0] top_a, top_b, mid_a, mid_b, bot_a, bot_b;

   // S1 registers
   logic [DATA_W-1:0] top_p1, mid_p1, bot_p1;
   logic [COL_W-1:0]  col_p1;
   logic              mode_p1;
   logic              vld_p1;

   // S2 combine
   logic [DATA_W-1:0] fin_a, fin_b;

   // Column of the current beat (sol restarts the line) and the centre it resolves
   always_comb begin
      beat_col = sol ? '0 : col_cnt;
      ctr_col  = (beat_col == '0) ? LAST_COL : beat_col - 1'b1;
   end

   // S0: shift the window on each accepted beat and tag it with its centre column
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt  <= '0;
         top_p0   <= '{default: '0};
         mid_p0   <= '{default: '0};
         bot_p0   <= '{default: '0};
         col_p0   <= '0;
         mode_p0  <= 1'b0;
         shape_p0 <= 1'b0;
         vld_p0   <= 1'b0;
      end else begin
         vld_p0 <= valid_in;
         if (valid_in) begin
            col_cnt  <= (beat_col == LAST_COL) ? '0 : beat_col + 1'b1;
            top_p0   <= '{top_p0[1], top_p0[2], din_top};
            mid_p0   <= '{mid_p0[1], mid_p0[2], din_mid};
            bot_p0   <= '{bot_p0[1], bot_p0[2], din_bot};
            col_p0   <= ctr_col;
            mode_p0  <= mode;
            shape_p0 <= shape;
         end
      end
   end

`ifdef MORPH_BORDER_MASK_EN
   logic [DATA_W-1:0] neut;
   logic              at_left, at_right;

   // Swap the column that lies outside the line for a value that cannot win
   always_comb begin
      neut     = DATA_W'(neutral_val(mode_p0, DATA_W));
      at_left  = (col_p0 == '0);
      at_right = (col_p0 == LAST_COL);
      lt = at_left  ? neut : top_p0[0];
      lm = at_left  ? neut : mid_p0[0];
      lb = at_left  ? neut : bot_p0[0];
      rt = at_right ? neut : top_p0[2];
      rm = at_right ? neut : mid_p0[2];
      rb = at_right ? neut : bot_p0[2];
   end
`else
   assign lt = top_p0[0];
   assign lm = mid_p0[0];
   assign lb = bot_p0[0];
   assign rt = top_p0[2];
   assign rm = mid_p0[2];
   assign rb = bot_p0[2];
`endif

   morph_sel2 #(.DATA_W(DATA_W)) u_top_a (.mode(mode_p0), .a(lt),    .b(top_p0[1]), .y(top_a));
   morph_sel2 #(.DATA_W(DATA_W)) u_top_b (.mode(mode_p0), .a(top_a), .b(rt),        .y(top_b));
   morph_sel2 #(.DATA_W(DATA_W)) u_mid_a (.mode(mode_p0), .a(lm),    .b(mid_p0[1]), .y(mid_a));
   morph_sel2 #(.DATA_W(DATA_W)) u_mid_b (.mode(mode_p0), .a(mid_a), .b(rm),        .y(mid_b));
   morph_sel2 #(.DATA_W(DATA_W)) u_bot_a (.mode(mode_p0), .a(lb),    .b(bot_p0[1]), .y(bot_a));
   morph_sel2 #(.DATA_W(DATA_W)) u_bot_b (.mode(mode_p0), .a(bot_a), .b(rb),        .y(bot_b));

   // S1: per-row partials; cross uses only the centre pixel of top and bottom rows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_p1  <= '0;
         mid_p1  <= '0;
         bot_p1  <= '0;
         col_p1  <= '0;
         mode_p1 <= 1'b0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            top_p1  <= (shape_p0 == SHAPE_SQUARE) ? top_b : top_p0[1];
            mid_p1  <= mid_b;
            bot_p1  <= (shape_p0 == SHAPE_SQUARE) ? bot_b : bot_p0[1];
            col_p1  <= col_p0;
            mode_p1 <= mode_p0;
         end
      end
   end

   morph_sel2 #(.DATA_W(DATA_W)) u_fin_a (.mode(mode_p1), .a(top_p1), .b(mid_p1), .y(fin_a));
   morph_sel2 #(.DATA_W(DATA_W)) u_fin_b (.mode(mode_p1), .a(fin_a),  .b(bot_p1), .y(fin_b));

   // S2: combine the row partials; outputs hold while no beat is present
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout      <= '0;
         col_out   <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= vld_p1;
         if (vld_p1) begin
            dout    <= fin_b;
            col_out <= col_p1;
         end
      end
   end

endmodule

// File: tb/tb_morph3x3_filter.sv
// Self-checking bench for morph3x3_filter (DATA_W=8, PIC_WIDTH=8).
// Expected results come from a pixel-history model: the window of a beat is
// the last three pixels seen on each row, operands are chosen by shape, and
// the result is a plain min/max over them.
module tb_morph3x3_filter;

   localparam int DW = 8;
   localparam int PW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_in = 1'b0;
   logic          sol = 1'b0;
   logic          mode = 1'b0;
   logic          shape = 1'b0;
   logic [DW-1:0] din_top = '0;
   logic [DW-1:0] din_mid = '0;
   logic [DW-1:0] din_bot = '0;
   logic          valid_out;
   logic [DW-1:0] dout;
   logic [CW-1:0] col_out;

   morph3x3_filter #(.DATA_W(DW), .PIC_WIDTH(PW), .COL_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sol(sol), .mode(mode),
      .shape(shape), .din_top(din_top), .din_mid(din_mid), .din_bot(din_bot),
      .valid_out(valid_out), .dout(dout), .col_out(col_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [DW-1:0] d;
      int            col;
      int            edg;
   } res_t;

   res_t exp_q[$];
   res_t got_q[$];
   int   hist_t[$], hist_m[$], hist_b[$];

   // Collect every emitted pixel together with the clock edge it appeared on
   always @(negedge clk) begin
      if (valid_out === 1'b1) got_q.push_back('{dout, int'(col_out), cyc});
   end

   function automatic void hist_reset();
      hist_t = '{0, 0};
      hist_m = '{0, 0};
      hist_b = '{0, 0};
   endfunction

   // min/max over the structuring-element pixels of the window centred on the
   // second-newest pixel; with border masking, out-of-line columns are dropped
   function automatic int ref_pix(input bit md, input bit sh, input int ccol);
      int n;
      int ops[$];
      int r;
      bit use_l;
      bit use_r;
      n = hist_m.size();
      use_l = 1'b1;
      use_r = 1'b1;
`ifdef MORPH_BORDER_MASK_EN
      if (ccol == 0) use_l = 1'b0;
      if (ccol == PW - 1) use_r = 1'b0;
`endif
      ops.push_back(hist_m[n-2]);
      ops.push_back(hist_t[n-2]);
      ops.push_back(hist_b[n-2]);
      if (use_l) ops.push_back(hist_m[n-3]);
      if (use_r) ops.push_back(hist_m[n-1]);
      if (sh) begin
         if (use_l) begin ops.push_back(hist_t[n-3]); ops.push_back(hist_b[n-3]); end
         if (use_r) begin ops.push_back(hist_t[n-1]); ops.push_back(hist_b[n-1]); end
      end
      r = ops[0];
      foreach (ops[i]) r = md ? ((ops[i] > r) ? ops[i] : r) : ((ops[i] < r) ? ops[i] : r);
      return r;
   endfunction

   // One cycle of stimulus; a beat at column k yields centre k-1 (or PW-1 for k=0)
   task automatic drive(input bit v, input int k, input bit md, input bit sh,
                        input logic [DW-1:0] t, input logic [DW-1:0] m, input logic [DW-1:0] b);
      int ccol;
      @(posedge clk);
      #1;
      valid_in = v;
      sol      = v ? (k == 0) : 1'($urandom);
      mode     = md;
      shape    = sh;
      din_top  = t;
      din_mid  = m;
      din_bot  = b;
      if (v) begin
         hist_t.push_back(int'(t));
         hist_m.push_back(int'(m));
         hist_b.push_back(int'(b));
         ccol = (k + PW - 1) % PW;
         exp_q.push_back('{DW'(ref_pix(md, sh, ccol)), ccol, cyc + 1});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic test_reset();
      hist_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b want 0", valid_out); end
      checks++; if (dout !== '0) begin failures++; $display("FAIL reset_dout got %0d want 0", dout); end
      checks++; if (col_out !== '0) begin failures++; $display("FAIL reset_col got %0d want 0", col_out); end
      rst_n = 1'b1;
      idle(4);
      checks++; if (got_q.size() != 0) begin failures++; $display("FAIL reset_idle_pulses got %0d want 0", got_q.size()); end
      got_q.delete();
   endtask

   task automatic test_erode_cross();
      for (int ln = 0; ln < 2; ln++)
         for (int k = 0; k < PW; k++)
            drive(1'b1, k, 1'b0, 1'b0, 8'd100, (k == 3) ? 8'd20 : 8'd100, 8'd100);
      drive(1'b1, 0, 1'b0, 1'b0, 8'd100, 8'd100, 8'd100);
      idle(4);
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL erode_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i].d !== exp_q[i].d) begin failures++; $display("FAIL erode_dout[%0d] got %0d want %0d", i, got_q[i].d, exp_q[i].d); end
         checks++; if (got_q[i].col != exp_q[i].col) begin failures++; $display("FAIL erode_col[%0d] got %0d want %0d", i, got_q[i].col, exp_q[i].col); end
         checks++; if (got_q[i].edg - exp_q[i].edg != 2) begin failures++; $display("FAIL erode_latency[%0d] got %0d want 2", i, got_q[i].edg - exp_q[i].edg); end
      end
      foreach (got_q[i]) begin
         if (got_q[i].col >= 2 && got_q[i].col <= 4) begin
            checks++; if (got_q[i].d !== 8'd20) begin failures++; $display("FAIL erode_hole[%0d] got %0d want 20", i, got_q[i].d); end
         end else if (got_q[i].col >= 1 && got_q[i].col <= 6) begin
            checks++; if (got_q[i].d !== 8'd100) begin failures++; $display("FAIL erode_flat[%0d] got %0d want 100", i, got_q[i].d); end
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_dilate_square();
      for (int ln = 0; ln < 2; ln++)
         for (int k = 0; k < PW; k++)
            drive(1'b1, k, 1'b1, 1'b1, (k == 5) ? 8'd200 : 8'd10, 8'd10, 8'd10);
      drive(1'b1, 0, 1'b1, 1'b1, 8'd10, 8'd10, 8'd10);
      idle(4);
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL dilate_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i].d !== exp_q[i].d) begin failures++; $display("FAIL dilate_dout[%0d] got %0d want %0d", i, got_q[i].d, exp_q[i].d); end
         checks++; if (got_q[i].col != exp_q[i].col) begin failures++; $display("FAIL dilate_col[%0d] got %0d want %0d", i, got_q[i].col, exp_q[i].col); end
         checks++; if (got_q[i].edg - exp_q[i].edg != 2) begin failures++; $display("FAIL dilate_latency[%0d] got %0d want 2", i, got_q[i].edg - exp_q[i].edg); end
      end
      foreach (got_q[i]) begin
         if (got_q[i].col >= 4 && got_q[i].col <= 6) begin
            checks++; if (got_q[i].d !== 8'd200) begin failures++; $display("FAIL dilate_peak[%0d] got %0d want 200", i, got_q[i].d); end
         end else if (got_q[i].col >= 1 && got_q[i].col <= 3) begin
            checks++; if (got_q[i].d !== 8'd10) begin failures++; $display("FAIL dilate_flat[%0d] got %0d want 10", i, got_q[i].d); end
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_border();
      int want7;
`ifdef MORPH_BORDER_MASK_EN
      want7 = 50;
`else
      want7 = 5;
`endif
      for (int ln = 0; ln < 2; ln++)
         for (int k = 0; k < PW; k++)
            drive(1'b1, k, 1'b0, 1'b0, 8'd50, (k == 0) ? 8'd5 : 8'd50, 8'd50);
      drive(1'b1, 0, 1'b0, 1'b0, 8'd50, 8'd5, 8'd50);
      idle(4);
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL border_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i].d !== exp_q[i].d) begin failures++; $display("FAIL border_dout[%0d] got %0d want %0d", i, got_q[i].d, exp_q[i].d); end
         checks++; if (got_q[i].col != exp_q[i].col) begin failures++; $display("FAIL border_col[%0d] got %0d want %0d", i, got_q[i].col, exp_q[i].col); end
      end
      foreach (got_q[i]) begin
         if (i >= 1 && got_q[i].col == PW - 1) begin
            checks++; if (got_q[i].d !== DW'(want7)) begin failures++; $display("FAIL border_c7[%0d] got %0d want %0d", i, got_q[i].d, want7); end
         end else if (got_q[i].col == 0) begin
            checks++; if (got_q[i].d !== 8'd5) begin failures++; $display("FAIL border_c0[%0d] got %0d want 5", i, got_q[i].d); end
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_gapped();
      for (int k = 0; k < PW; k++) begin
         drive(1'b1, k, 1'b0, 1'b0, 8'd100, (k == 3) ? 8'd20 : 8'd100, 8'd100);
         idle(1);
      end
      drive(1'b1, 0, 1'b0, 1'b0, 8'd100, 8'd100, 8'd100);
      idle(4);
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL gapped_pulses got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i].d !== exp_q[i].d) begin failures++; $display("FAIL gapped_dout[%0d] got %0d want %0d", i, got_q[i].d, exp_q[i].d); end
         checks++; if (got_q[i].col != exp_q[i].col) begin failures++; $display("FAIL gapped_col[%0d] got %0d want %0d", i, got_q[i].col, exp_q[i].col); end
         checks++; if (got_q[i].edg - exp_q[i].edg != 2) begin failures++; $display("FAIL gapped_latency[%0d] got %0d want 2", i, got_q[i].edg - exp_q[i].edg); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_mode_switch();
      for (int k = 0; k < PW; k++)
         drive(1'b1, k, 1'(k % 2), 1'b0, 8'd100, (k == 3) ? 8'd20 : 8'd100, 8'd100);
      drive(1'b1, 0, 1'b0, 1'b0, 8'd100, 8'd100, 8'd100);
      idle(4);
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL modesw_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i].d !== exp_q[i].d) begin failures++; $display("FAIL modesw_dout[%0d] got %0d want %0d", i, got_q[i].d, exp_q[i].d); end
      end
      foreach (got_q[i]) begin
         if (got_q[i].col == 3) begin
            checks++; if (got_q[i].d !== 8'd20) begin failures++; $display("FAIL modesw_erode_c3 got %0d want 20", got_q[i].d); end
         end else if (got_q[i].col == 2) begin
            checks++; if (got_q[i].d !== 8'd100) begin failures++; $display("FAIL modesw_dilate_c2 got %0d want 100", got_q[i].d); end
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_midline_reset();
      for (int k = 0; k < 5; k++)
         drive(1'b1, k, 1'b0, 1'b0, 8'd100, 8'd100, 8'd100);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL midreset_valid got %0b want 0", valid_out); end
      checks++; if (dout !== '0) begin failures++; $display("FAIL midreset_dout got %0d want 0", dout); end
      checks++; if (col_out !== '0) begin failures++; $display("FAIL midreset_col got %0d want 0", col_out); end
      got_q.delete(); exp_q.delete();
      hist_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < PW; k++)
         drive(1'b1, k, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      idle(4);
      checks++; if (got_q.size() != PW) begin failures++; $display("FAIL midreset_count got %0d want %0d", got_q.size(), PW); end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         checks++; if (got_q[i].col != (i + PW - 1) % PW) begin failures++; $display("FAIL midreset_colseq[%0d] got %0d want %0d", i, got_q[i].col, (i + PW - 1) % PW); end
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i].d !== exp_q[i].d) begin failures++; $display("FAIL midreset_dout[%0d] got %0d want %0d", i, got_q[i].d, exp_q[i].d); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      for (int ln = 0; ln < 4; ln++)
         for (int k = 0; k < PW; k++) begin
            drive(1'b1, k, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            idle($urandom_range(0, 2));
         end
      idle(4);
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i].d !== exp_q[i].d) begin failures++; $display("FAIL random_dout[%0d] got %0d want %0d", i, got_q[i].d, exp_q[i].d); end
         checks++; if (got_q[i].col != exp_q[i].col) begin failures++; $display("FAIL random_col[%0d] got %0d want %0d", i, got_q[i].col, exp_q[i].col); end
         checks++; if (got_q[i].edg - exp_q[i].edg != 2) begin failures++; $display("FAIL random_latency[%0d] got %0d want 2", i, got_q[i].edg - exp_q[i].edg); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_erode_cross();
      test_dilate_square();
      test_border();
      test_gapped();
      test_mode_switch();
      test_midline_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
